uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmit channel between `NUM_REQ` on-chip requesters. It captures one word from the winning requester and drives the UART's `TX_in`/`send` inputs. It then tracks the transmitter's `tx_busy` handshake until the frame is finished. It sits between the requesting blocks and the UART top and runs on the system clock, not the baud clock.

## Interface
Parameters:
- `WORD_LENGHT`, default 8: data word width; must match the UART instance.
- `NUM_REQ`, default 4: number of requesters, range 1..16.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset. Synchronous, active-high.
- `req` in `NUM_REQ`: per-requester level request. The requester holds it, with its data, until granted.
- `req_data` in `NUM_REQ*WORD_LENGHT`: packed data. Requester i uses bits `[i*WORD_LENGHT +: WORD_LENGHT]`.
- `grant` out `NUM_REQ`: one-hot, one-cycle pulse. Marks the cycle the winner's word was captured.
- `tx_data` out `WORD_LENGHT`: to UART `TX_in`. Held stable from capture until the frame is done.
- `tx_send` out 1: to UART `send`. A level held until `tx_busy` is seen high.
- `tx_busy` in 1: from the UART transmitter. High while a frame is shifting.
- `busy` out 1: high in every state except IDLE.
- `last_id` out `CeilLog2(NUM_REQ)`: index of the most recent grant.

## Operation
- The FSM has four states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If `tx_busy`=0 and any `req` bit is set, the arbiter picks a winner and captures `req_data[winner]` into `tx_data`.
  - It pulses `grant[winner]`, updates `last_id`, and goes to LOAD.
  - If `tx_busy`=1 on entry (a foreign frame is in flight), it stays in IDLE.
- LOAD: assert `tx_send`, then go to WAIT_BUSY.
- WAIT_BUSY: keep `tx_send`=1 until `tx_busy`=1 is sampled. On that edge, drop `tx_send` and go to WAIT_DONE. There is no timeout, because the baud clock is slow relative to `clk`.
- WAIT_DONE: when `tx_busy`=0 is sampled, return to IDLE.
- Round-robin pointer:
  - The search starts at `ptr` and wraps upward modulo `NUM_REQ`. The first set `req` wins.
  - After a grant to i, `ptr` = (i+1) mod `NUM_REQ`.
  - Reset sets `ptr` to 0.
- A requester samples `grant`. It may drop `req` or present new data on the cycle after the grant. If it keeps `req` high, it competes again in the next arbitration.
- If `req` is deasserted before the grant, no grant is issued and no data is captured.
- With `NUM_REQ`=1, the arbiter degenerates to a single-requester sequencer and `ptr` stays at 0.

## Timing
- Reset values: `grant`=0, `tx_data`=0, `tx_send`=0, `busy`=0, `last_id`=0. State is IDLE and `ptr`=0.
- Arbitration latency is 1 cycle. If `req` is seen at edge N in IDLE, then `grant` and `tx_data` are valid after edge N.
- `tx_send` rises after edge N+1.
- Minimum IDLE-to-IDLE time is 3 cycles plus the `tx_busy` high time.
- `grant` is never asserted for two consecutive cycles.
- IDLE is the only state that can issue a grant.
- When several `req` bits are set together, the order is strictly by `ptr`, so no requester starves. Each of the other requesters waits at most `NUM_REQ`-1 frames.
- If `tx_busy` goes high and low between two `clk` samples, the transfer stalls in WAIT_BUSY. This is not supported: `tx_busy` must stay high for at least 2 `clk` cycles.
- Reset mid-operation returns everything to reset values at the next edge. The in-flight word is dropped and its grant is not reissued.

## Configuration
- `UART_ARB_ID_HEADER_EN` defined:
  - Each transfer sends two frames. The first is a header word equal to the winner index zero-extended to `WORD_LENGHT`; the second is the payload.
  - Both values are captured at the grant. The sequence LOAD→WAIT_BUSY→WAIT_DONE runs twice, tracked by a header/payload phase bit.
  - `grant` still pulses once, at capture.
- `UART_ARB_ID_HEADER_EN` undefined: one frame per grant, payload only, and no phase bit exists.

## Structure
- Shared package `Definitions`:
  - `CeilLog2`, used for the widths of `last_id` and `ptr`.
  - typedef enum `uart_arb_state_e` with values IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- Sub-module `rr_priority_picker`: combinational. Takes `req` and `ptr`; returns `valid`, a one-hot winner, and the winner index. The top block holds all registers.

## Test plan
- After reset with all `req`=0: every output is 0 and `busy`=0 for 10 cycles.
- `req`=4'b0001 with data 0x41; the bench models `tx_busy` high for 20 cycles, starting 5 cycles after `tx_send`:
  - `grant`=0001 for one cycle and `tx_data`=0x41.
  - `tx_send` stays high for exactly 6 cycles; `busy` drops one cycle after `tx_busy` falls.
- `req`=4'b1111 held, with data 0x10..0x13: grants go 0,1,2,3,0 in that order and `tx_data` follows the same sequence.
- `tx_busy`=1 before a request, then `req`=0010: no grant until `tx_busy`=0 is sampled; the grant follows one cycle later.
- `rst` pulsed during WAIT_DONE: all outputs return to 0 and the next `req`=1000 is granted with `ptr` starting from 0.
- With `UART_ARB_ID_HEADER_EN` defined, `req`=0100 with data 0x5A: `tx_data` presents 0x02, then 0x5A, with two `tx_send` handshakes and a single `grant` pulse.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the round-robin UART transmit arbiter.
// Used by uart_tx_arbiter and rr_priority_picker.
package Definitions;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } uart_arb_state_e;

    // Never returns 0 so a single requester still gets a 1-bit index.
    function automatic int CeilLog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_priority_picker
    import Definitions::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = CeilLog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDW-1:0]     idx_o
);

    localparam logic [IDW:0] NQ = (IDW+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDW:0]         off;
    logic [IDW:0]         sum;

    always_comb begin
        // Rotate so that bit 0 is the requester at ptr.
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = (IDW+1)'(k);
        end
        sum = {1'b0, ptr_i} + off;
        if (sum >= NQ) sum = sum - NQ;
        valid_o  = |req_i;
        idx_o    = sum[IDW-1:0];
        onehot_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            onehot_o[i] = valid_o && (idx_o == IDW'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART TX between NUM_REQ blocks.
// Define UART_ARB_ID_HEADER_EN to prefix each payload with a winner-id frame.
module uart_tx_arbiter
    import Definitions::*;
#(
    parameter int WORD_LENGHT = 8,
    parameter int NUM_REQ     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WORD_LENGHT-1:0] req_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [WORD_LENGHT-1:0]         tx_data,
    output logic                           tx_send,
    input  logic                           tx_busy,
    output logic                           busy,
    output logic [CeilLog2(NUM_REQ)-1:0]   last_id
);

    localparam int IDW = CeilLog2(NUM_REQ);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

    uart_arb_state_e        state_q;
    logic [IDW-1:0]         ptr_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [WORD_LENGHT-1:0] tx_data_q;
    logic                   tx_send_q;
    logic [IDW-1:0]         last_id_q;
`ifdef UART_ARB_ID_HEADER_EN
    logic [WORD_LENGHT-1:0] payload_q;
    logic                   phase_q;
`endif

    logic                   pick_valid;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [IDW-1:0]         pick_idx;
    logic [WORD_LENGHT-1:0] win_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) win_data = req_data[i*WORD_LENGHT +: WORD_LENGHT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
            last_id_q <= '0;
`ifdef UART_ARB_ID_HEADER_EN
            payload_q <= '0;
            phase_q   <= 1'b0;
`endif
        end else begin
            grant_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (!tx_busy && pick_valid) begin
                        grant_q   <= pick_oh;
                        last_id_q <= pick_idx;
                        ptr_q     <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
`ifdef UART_ARB_ID_HEADER_EN
                        tx_data_q <= WORD_LENGHT'(pick_idx);
                        payload_q <= win_data;
                        phase_q   <= 1'b0;
`else
                        tx_data_q <= win_data;
`endif
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    tx_send_q <= 1'b1;
                    state_q   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        tx_send_q <= 1'b0;
                        state_q   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef UART_ARB_ID_HEADER_EN
                        // Header frame done: queue the payload frame.
                        if (!phase_q) begin
                            phase_q   <= 1'b1;
                            tx_data_q <= payload_q;
                            state_q   <= LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign tx_data = tx_data_q;
    assign tx_send = tx_send_q;
    assign last_id = last_id_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART model.
// Honours UART_ARB_ID_HEADER_EN for the expected frame sequence.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_ID_HEADER_EN
    localparam int FRAMES = 2;
`else
    localparam int FRAMES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        busy;
    logic [1:0]  last_id;

    logic uart_busy  = 1'b0;
    logic force_busy = 1'b0;
    int   ud = 5;
    int   uh = 20;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   n_send = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   mptr = 0;

    int         gq[$];
    logic [7:0] dq[$];
    logic [7:0] fq[$];

    assign tx_busy = uart_busy | force_busy;

    uart_tx_arbiter #(.WORD_LENGHT(8), .NUM_REQ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .busy     (busy),
        .last_id  (last_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first set request scanning upward from mptr.
    function automatic int pick(input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(mptr + k) % 4]) return (mptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic expect_grant(input int w, input logic [7:0] d);
        gq.push_back(w);
        dq.push_back(d);
        if (FRAMES == 2) fq.push_back(8'(w));
        fq.push_back(d);
        mptr = (w + 1) % 4;
    endtask

    // UART transmitter model: busy starts ud cycles after send, lasts uh.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send && !uart_busy) begin
                repeat (ud) @(negedge clk);
                uart_busy = 1'b1;
                repeat (uh) @(negedge clk);
                uart_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Monitor: checks grants and frame data against the scoreboard.
    logic [3:0] pg = '0;
    logic       ps = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (grant != 0) begin
                chk("grant_back_to_back", 32'(pg != 0), 32'd0);
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 32'(grant), 32'd0);
                end else begin
                    int         w;
                    logic [7:0] d;
                    w = gq.pop_front();
                    d = dq.pop_front();
                    chk("grant_onehot", 32'(grant), 32'(1 << w));
                    chk("last_id", 32'(last_id), 32'(w));
                    chk("tx_data_capture", 32'(tx_data),
                        (FRAMES == 2) ? 32'(w) : 32'(d));
                end
            end
            if (tx_send && !ps) begin
                n_send++;
                if (fq.size() == 0) chk("send_unexpected", 32'(tx_send), 32'd0);
                else chk("frame_data", 32'(tx_data), 32'(fq.pop_front()));
            end
        end
        pg = rst ? 4'd0 : grant;
        ps = rst ? 1'b0 : tx_send;
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && !uart_busy) break;
        end
        if (i == 2000) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_round(input logic [3:0] mask, input logic [31:0] dat,
                             input int held_n);
        logic [3:0] m;
        int         gcount;
        int         i;
        m = mask;
        if (held_n == 0) begin
            while (m != 0) begin
                int w;
                w = pick(m);
                expect_grant(w, dat[w*8 +: 8]);
                m[w] = 1'b0;
            end
        end else begin
            repeat (held_n) begin
                int w;
                w = pick(mask);
                expect_grant(w, dat[w*8 +: 8]);
            end
        end
        req_data = dat;
        req = mask;
        gcount = 0;
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (grant != 0) begin
                gcount++;
                if (held_n == 0) req = req & ~grant;
                else if (gcount == held_n) req = '0;
            end
            if (req == 0 && !busy && gq.size() == 0) break;
        end
        if (i == 5000) chk("round_timeout", 32'd0, 32'd1);
        wait_idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int i;
        int cnt;
        int s0;
        rst = 1'b1;
        req = '0;
        req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_tx_data", 32'(tx_data), 32'd0);
            chk("rst_tx_send", 32'(tx_send), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_last_id", 32'(last_id), 32'd0);
        end

        // Single request, directed timing
        ud = 5; uh = 20;
        expect_grant(0, 8'h41);
        req_data = 32'h0000_0041;
        req = 4'b0001;
        for (i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (grant != 0) break;
        end
        chk("arb_latency", 32'(i), 32'd1);
        chk("send_before", 32'(tx_send), 32'd0);
        @(negedge clk);
        req = '0;
        chk("send_rise", 32'(tx_send), 32'd1);
        cnt = 1;
        for (i = 0; i < 100 && tx_send; i++) begin
            @(negedge clk);
            if (tx_send) cnt++;
        end
        chk("send_high_cycles", 32'(cnt), 32'd6);
        for (i = 0; i < 500; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("busy_drop_delay", 32'(cyc - fall_cyc), 32'd1);
        wait_idle();

        // Foreign frame in flight before the request
        ud = 2; uh = 4;
        force_busy = 1'b1;
        @(negedge clk);
        expect_grant(1, 8'h22);
        req_data = 32'h0000_2200;
        req = 4'b0010;
        repeat (8) begin
            @(negedge clk);
            chk("grant_while_busy", 32'(grant), 32'd0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("grant_after_busy", 32'(grant), 32'b0010);
        @(negedge clk);
        req = '0;
        wait_idle();

        // Reset during WAIT_DONE
        ud = 1; uh = 20;
        expect_grant(2, 8'h77);
        s0 = n_send;
        req_data = 32'h0077_0000;
        req = 4'b0100;
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if (grant != 0) req = '0;
            if (n_send == s0 + FRAMES && uart_busy && !tx_send) break;
        end
        chk("reach_wait_done", 32'(i < 500), 32'd1);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_tx_send", 32'(tx_send), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_last_id", 32'(last_id), 32'd0);
        rst = 1'b0;
        mptr = 0;
        wait_idle();

        ud = 3; uh = 5;
        run_round(4'b1000, 32'h3300_0000, 0);
        run_round(4'b1111, 32'h1312_1110, 5);
        run_round(4'b0100, 32'h005A_0000, 0);

        for (int r = 0; r < 25; r++) begin
            ud = $urandom_range(0, 6);
            uh = $urandom_range(2, 10);
            run_round(4'($urandom_range(1, 15)), $urandom, 0);
        end

        chk("grant_queue_empty", 32'(gq.size()), 32'd0);
        chk("frame_queue_empty", 32'(fq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
